// File: rtl/riscv_pkg.sv
// Shared front-end definitions: datapath width, canonical NOP and the
// fetch packet carried from FE to decode.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;
endpackage

// File: rtl/fdb_storage.sv
// Entry storage for the fetch/decode buffer: DEPTH packets, one write port,
// one asynchronous read port. Contents are intentionally not reset; the
// owner qualifies reads with its own valid tracking.
module fdb_storage
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  fetch_pkt_t       wdata,
  input  logic [AW-1:0]    raddr,
  output fetch_pkt_t       rdata
);

  fetch_pkt_t mem [DEPTH];

  // Write the incoming packet into the addressed slot
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Decode-side receiver for FE output: a small circular buffer of {inst, pc}
// pairs presented in order to decode. en_pc_fe is backpressure to FE and
// comes only from the registered count, so a full buffer never accepts a
// word in the same cycle it frees a slot. flush drops everything, including
// the pair FE presents in the flush cycle.
module fetch_decode_buffer #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [XLEN-1:0]            fe_inst,
  input  logic [XLEN-1:0]            fe_pc,
  input  logic                       fe_valid,
  output logic                       en_pc_fe,
  output logic [XLEN-1:0]            de_inst,
  output logic [XLEN-1:0]            de_pc,
  output logic                       de_valid,
  input  logic                       de_stall,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  import riscv_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  fetch_pkt_t       wr_pkt, rd_pkt;

  assign en_pc_fe = (count != FULL_CNT);
  assign de_valid = (count != '0);
  assign push     = fe_valid & en_pc_fe & ~flush;
  assign pop      = de_valid & ~de_stall & ~flush;

  assign wr_pkt.inst = fe_inst;
  assign wr_pkt.pc   = fe_pc;

  fdb_storage #(.DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_pkt),
    .raddr (rd_ptr),
    .rdata (rd_pkt)
  );

  // Pointer and occupancy bookkeeping; flush overrides push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head presentation: NOP/0 whenever the buffer is empty
  always_comb begin
    de_inst = NOP_INST;
    de_pc   = '0;
    if (de_valid) begin
      de_inst = rd_pkt.inst;
      de_pc   = rd_pkt.pc;
    end
  end

  assign occupancy = count;

endmodule
